// File: rtl/frame_read_sched.sv
// Reads one frame from SDRAM over Avalon-MM bursts and streams it out as a single Avalon-ST packet.
// Defining FRS_UNDERRUN_CNT_EN adds the saturating underrun_cnt output.
module frame_read_sched #(
    parameter int FRAME_WORDS = 76800,
    parameter int MAX_BURST   = 8,
    parameter int BUF_DEPTH   = 32
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        ctrl_start,
    input  logic [31:0] ctrl_base,
    output logic        ctrl_busy,
    output logic        ctrl_done,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [4:0]  avm_burstcount,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [31:0] st_data,
    output logic        st_valid,
    input  logic        st_ready,
    output logic        st_startofpacket,
    output logic        st_endofpacket
`ifdef FRS_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);
    localparam int CW = $clog2(FRAME_WORDS + 1);
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam int AW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   req_left_q, req_left_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [4:0]      burst_q, burst_d;
    logic            read_q, read_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [31:0]     mem [BUF_DEPTH];

    logic            accept;
    logic            push;
    logic            pop;
    logic [4:0]      len;
    logic            credit_ok;

    // Words arriving with nothing outstanding belong to a burst cut off by reset and are dropped.
    assign accept    = read_q && !avm_waitrequest;
    assign push      = avm_readdatavalid && (outst_q != '0);
    assign pop       = st_valid && st_ready;
    assign len       = (32'(req_left_q) >= MAX_BURST) ? 5'(MAX_BURST) : 5'(req_left_q);
    assign credit_ok = (32'(occ_q) + 32'(outst_q) + 32'(len)) <= BUF_DEPTH;

    always_comb begin
        state_d    = state_q;
        req_left_d = req_left_q;
        out_cnt_d  = out_cnt_q;
        addr_d     = addr_q;
        burst_d    = burst_q;
        read_d     = read_q;
        occ_d      = occ_q;
        outst_d    = outst_q;

        if (accept) begin
            read_d  = 1'b0;
            addr_d  = addr_q + {25'd0, burst_q, 2'b00};
            outst_d = outst_d + OW'(burst_q);
        end
        if (push) begin
            outst_d = outst_d - OW'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OW'(1);
        end
        if (pop) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end

        // Only one burst is in the command phase at a time, so the credit check always sees it in outst.
        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    state_d    = ISSUE;
                    req_left_d = CW'(FRAME_WORDS);
                    out_cnt_d  = '0;
                    addr_d     = ctrl_base;
                end
            end
            ISSUE: begin
                if (!read_q) begin
                    if (req_left_q == '0) begin
                        state_d = DRAIN;
                    end else if (credit_ok) begin
                        read_d     = 1'b1;
                        burst_d    = len;
                        req_left_d = req_left_q - CW'(len);
                    end
                end
            end
            DRAIN: begin
                if (pop && (out_cnt_q == CW'(FRAME_WORDS - 1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= IDLE;
            req_left_q <= '0;
            out_cnt_q  <= '0;
            addr_q     <= '0;
            burst_q    <= '0;
            read_q     <= 1'b0;
            occ_q      <= '0;
            outst_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_left_q <= req_left_d;
            out_cnt_q  <= out_cnt_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            read_q     <= read_d;
            occ_q      <= occ_d;
            outst_q    <= outst_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= avm_readdata;
        end
    end

    assign avm_address      = addr_q;
    assign avm_read         = read_q;
    assign avm_burstcount   = burst_q;
    assign st_valid         = (occ_q != '0);
    assign st_data          = st_valid ? mem[rd_ptr_q] : 32'd0;
    assign st_startofpacket = st_valid && (out_cnt_q == '0);
    assign st_endofpacket   = st_valid && (out_cnt_q == CW'(FRAME_WORDS - 1));
    assign ctrl_busy        = (state_q == ISSUE) || (state_q == DRAIN);
    assign ctrl_done        = (state_q == DONE);

`ifdef FRS_UNDERRUN_CNT_EN
    logic [15:0] underrun_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            underrun_q <= '0;
        end else if ((state_q == IDLE) && ctrl_start) begin
            underrun_q <= '0;
        end else if (ctrl_busy && st_ready && !st_valid && (underrun_q != 16'hFFFF)) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_q;
`endif

endmodule

// File: doc/frame_read_sched.md
FRAME_READ_SCHED -- requirements
Module: frame_read_sched

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 76800, meaning the 32-bit words per frame (320x480 at 16 bpp, packed two pixels per word).
REQ-002 SHALL have parameter MAX_BURST, default 8, meaning the maximum Avalon-MM read burst length in words (power of two, 2..16).
REQ-003 SHALL have parameter BUF_DEPTH, default 32, meaning the internal read-data buffer depth in words (power of two, >= 2*MAX_BURST).
REQ-004 SHALL have port clk_clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset_reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port ctrl_start  in  1  frame start request, sampled high for one cycle.
REQ-007 SHALL have port ctrl_base  in  32  frame base byte address, 4-byte aligned, captured on an accepted start.
REQ-008 SHALL have port ctrl_busy  out  1  high from an accepted start until the cycle done pulses.
REQ-009 SHALL have port ctrl_done  out  1  one-cycle pulse when a frame completes.
REQ-010 SHALL have ports avm_address out 32, avm_read out 1, avm_burstcount out 5, avm_waitrequest in 1, avm_readdata in 32, avm_readdatavalid in 1, forming an Avalon-MM burst read master to the SDRAM controller.
REQ-011 SHALL have ports st_data out 32, st_valid out 1, st_ready in 1, st_startofpacket out 1, st_endofpacket out 1, forming an Avalon-ST source of one packet per frame.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE: IDLE->ISSUE on ctrl_start; ISSUE->DRAIN when all words are requested; DRAIN->DONE when every word has left st_*; DONE->IDLE after exactly one cycle.
REQ-013 SHALL ignore ctrl_start outside IDLE.
REQ-014 SHALL in ISSUE assert avm_read with burst length = min(MAX_BURST, remaining words) only when (buffer occupancy + outstanding words + that length) <= BUF_DEPTH.
REQ-015 SHALL hold avm_address, avm_burstcount and avm_read stable while avm_waitrequest is high; a burst counts as accepted on the cycle avm_read=1 and avm_waitrequest=0.
REQ-016 SHALL advance the address by 4*burstcount bytes per accepted burst, with 32-bit wrap-around and no carry beyond bit 31.
REQ-017 SHALL write every avm_readdatavalid word into the buffer in one cycle; the credit rule guarantees no overflow, and no word SHALL be dropped.
REQ-018 SHALL present buffer-head data on st_data with st_valid=1 whenever the buffer is non-empty; the word pops when st_valid and st_ready are both high.
REQ-019 SHALL assert st_startofpacket with word 0 and st_endofpacket with word FRAME_WORDS-1 of each frame, both qualified by st_valid.
REQ-020 SHALL update occupancy correctly on a simultaneous push and pop (net 0), and on a simultaneous burst accept and readdatavalid.
REQ-021 SHALL have first-word latency of 1 cycle from readdatavalid to st_valid; ctrl_done SHALL pulse 1 cycle after the eop word is accepted.
REQ-022 SHALL support FRAME_WORDS not a multiple of MAX_BURST, with the final burst shortened.

Reset
REQ-023 SHALL, on reset_reset_n low, immediately force the FSM to IDLE, empty the buffer, and clear all outputs to 0 (avm_address and avm_burstcount included), regardless of in-flight reads.
REQ-024 SHALL, after reset deassertion mid-frame, discard no data other than that flushed by reset, and accept a new start normally.

Configuration
REQ-025 SHALL, when macro FRS_UNDERRUN_CNT_EN is defined, add port underrun_cnt out 16: a counter that saturates at 0xFFFF, increments each cycle ctrl_busy=1, st_ready=1 and st_valid=0, clears on an accepted start, and resets to 0.
REQ-026 SHALL, when FRS_UNDERRUN_CNT_EN is undefined, omit the port and the counter logic entirely, with all other behaviour identical.

Verification
REQ-027 SHALL cover basic frame: FRAME_WORDS=16, MAX_BURST=4, base 0x100, no waitrequest, st_ready=1 -> bursts at 0x100, 0x110, 0x120, 0x130 of count 4; 16 words out in order with sop on word 0 and eop on word 15; one-cycle done pulse.
REQ-028 SHALL cover odd length: FRAME_WORDS=10, MAX_BURST=4 -> burstcounts 4, 4, 2; eop on word 9.
REQ-029 SHALL cover backpressure: BUF_DEPTH=8, MAX_BURST=4, st_ready=0 for 50 cycles -> at most 8 words requested, no overflow; all data intact after st_ready=1.
REQ-030 SHALL cover waitrequest: waitrequest high for 5 cycles on the 2nd burst -> address and count held constant; no duplicate burst issued.
REQ-031 SHALL cover reset mid-frame: reset_reset_n low at word 7 -> all outputs 0 and busy=0; a subsequent start at base 0x200 yields a complete, correct frame.
REQ-032 SHALL cover underrun (macro defined): st_ready=1 and readdatavalid withheld for 12 busy cycles -> underrun_cnt=12.
